load_store_unit: RTL and testbench

Memory-stage access unit between the EX/MEM pipeline boundary and `DATA_MEMORY`. Accepts one load/store request at a time and performs MIPS byte/halfword/word accesses (LB, LBU, LH, LHU, LW, SB, SH, SW) on a word-only data memory. Sub-word stores use read-modify-write. Loads return sign- or zero-extended results. Misaligned accesses are flagged and never reach memory.

---
 rtl/load_store_unit_pkg.sv | 35 +++
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit_byte_lane.sv | 59 +++++
 rtl/load_store_unit.sv | 106 ++++++++++
 tb/tb_load_store_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } lsu_state_t;

  function automatic logic is_store(input mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Halfwords need an even address, words need a word-aligned address.
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] low);
    case (op)
      LH, LHU, SH: return low[0];
      LW, SW:      return |low;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
interface load_store_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_misalign;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wd;
  logic          dm_we;
  logic [DW-1:0] dm_rd;

  // Pipeline and memory side.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, dm_rd,
    input  req_ready, resp_valid, resp_rdata, resp_misalign, dm_addr, dm_wd, dm_we
  );

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, dm_rd,
    output req_ready, resp_valid, resp_rdata, resp_misalign, dm_addr, dm_wd, dm_we
  );
endinterface

// File: rtl/load_store_unit_byte_lane.sv
// Big-endian byte-lane extract/extend for loads and lane merge for sub-word stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Select the addressed byte/halfword; offset 0 is the most significant lane.
  always_comb begin
    case (offset)
      2'd0:    lane_byte = word[31:24];
      2'd1:    lane_byte = word[23:16];
      2'd2:    lane_byte = word[15:8];
      default: lane_byte = word[7:0];
    endcase
    lane_half = offset[1] ? word[15:0] : word[31:16];
  end

  // Sign- or zero-extend the selected lane into the load result.
  always_comb begin
    case (op)
      LB:      load_val = {{24{lane_byte[7]}}, lane_byte};
      LBU:     load_val = {24'd0, lane_byte};
      LH:      load_val = {{16{lane_half[15]}}, lane_half};
      LHU:     load_val = {16'd0, lane_half};
      default: load_val = word;
    endcase
  end

  // Replace the target lane of the fetched word with right-aligned store data.
  always_comb begin
    merged = word;
    case (op)
      SB: begin
        case (offset)
          2'd0:    merged[31:24] = wdata[7:0];
          2'd1:    merged[23:16] = wdata[7:0];
          2'd2:    merged[15:8]  = wdata[7:0];
          default: merged[7:0]   = wdata[7:0];
        endcase
      end
      SH: begin
        if (offset[1]) merged[15:0]  = wdata[15:0];
        else           merged[31:16] = wdata[15:0];
      end
      SW:      merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request at a time, read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  lsu_state_t    state;
  lsu_state_t    state_next;
  mem_op_t       req_op;
  mem_op_t       op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] merge_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] lane_word;
  logic [DW-1:0] lane_load;
  logic [DW-1:0] lane_merged;

  assign req_op = mem_op_t'(bus.req_op);

  // READ works on the live memory word, WRITE on the captured merge word.
  assign lane_word = (state == S_READ) ? bus.dm_rd : merge_q;

  lsu_byte_lane u_lane (
    .op       (op_q),
    .offset   (addr_q[1:0]),
    .word     (lane_word),
    .wdata    (wdata_q),
    .load_val (lane_load),
    .merged   (lane_merged)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and output decode.
  always_comb begin
    state_next        = state;
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_misalign = 1'b0;
    bus.resp_rdata    = rdata_q;
    bus.dm_addr       = {addr_q[AW-1:2], 2'b00};
    bus.dm_wd         = '0;
    bus.dm_we         = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (is_misaligned(req_op, bus.req_addr[1:0])) state_next = S_RESP;
          else if (req_op == SW)                        state_next = S_WRITE;
          else                                          state_next = S_READ;
        end
      end
      S_READ:  state_next = is_store(op_q) ? S_WRITE : S_RESP;
      S_WRITE: begin
        bus.dm_we  = 1'b1;
        bus.dm_wd  = lane_merged;
        state_next = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid    = 1'b1;
        bus.resp_misalign = is_misaligned(op_q, addr_q[1:0]);
        state_next        = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Request latch, merge capture and load result; result clears on accept so stores/misaligned report 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= LB;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= req_op;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
          end
        end
        S_READ: begin
          if (is_store(op_q)) merge_q <= bus.dm_rd;
          else                rdata_q <= lane_load;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-addressed reference memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.AW(32), .DW(32)) bus ();

  load_store_unit #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Word-only data memory seen by the DUT.
  logic [31:0] mem [64];
  assign bus.dm_rd = mem[bus.dm_addr[7:2]];
  always @(posedge clk) if (bus.dm_we) mem[bus.dm_addr[7:2]] <= bus.dm_wd;

  // Reference: plain big-endian byte array.
  logic [7:0] rb [256];

  int n_checks = 0;
  int n_pass   = 0;
  int last_waits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {rb[b], rb[b+1], rb[b+2], rb[b+3]};
  endfunction

  task automatic set_word(input logic [7:0] a, input logic [31:0] w);
    mem[a[7:2]] = w;
    for (int i = 0; i < 4; i++) rb[{a[7:2], 2'b00} + i] = w[31-8*i -: 8];
  endtask

  // Issue one request (called at a negedge) and check its whole transaction.
  task automatic run_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                        input bit hold, input mem_op_t nop, input logic [31:0] naddr,
                        input logic [31:0] nwd);
    logic [7:0]  a;
    bit          mis, st, got, early_ready;
    logic [31:0] exp_rd, rd, addr_seen;
    logic        misq;
    int          exp_lat, lat, we_cnt, we_pos, waits;
    int          v;
    string       nm;
    a = addr[7:0];
    nm = $sformatf("%s@%h", op.name(), addr);
    mis = ((op == LH || op == LHU || op == SH) && a[0]) || ((op == LW || op == SW) && a[1:0] != 2'b00);
    st  = (op == SB || op == SH || op == SW);
    exp_rd = 32'd0;
    if (!mis && !st) begin
      case (op)
        LB:      begin v = $signed(rb[a]); exp_rd = v; end
        LBU:     exp_rd = {24'd0, rb[a]};
        LH:      begin v = $signed({rb[a], rb[8'(a + 8'd1)]}); exp_rd = v; end
        LHU:     exp_rd = {16'd0, rb[a], rb[8'(a + 8'd1)]};
        default: exp_rd = ref_word(a);
      endcase
    end
    exp_lat = mis ? 1 : ((op == SB || op == SH) ? 3 : 2);

    bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
    waits = 0;
    while (!bus.req_ready && waits < 10) begin @(negedge clk); waits++; end
    last_waits = waits;
    check({nm, " accept"}, 32'(waits < 10), 32'd1);
    @(posedge clk);

    got = 0; early_ready = 0; lat = 0; we_cnt = 0; we_pos = -1;
    rd = 'x; misq = 1'bx; addr_seen = 'x;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin bus.req_op = nop; bus.req_addr = naddr; bus.req_wdata = nwd; end
        else bus.req_valid = 1'b0;
        addr_seen = bus.dm_addr;
      end
      if (bus.dm_we) begin we_cnt++; we_pos = k; end
      if (bus.resp_valid) begin
        got = 1; lat = k; rd = bus.resp_rdata; misq = bus.resp_misalign;
        break;
      end else if (bus.req_ready) early_ready = 1;
    end

    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    check({nm, " rdata"}, rd, exp_rd);
    check({nm, " misalign"}, {31'd0, misq}, {31'd0, mis});
    check({nm, " we_count"}, 32'(we_cnt), (st && !mis) ? 32'd1 : 32'd0);
    check({nm, " we_pos"}, 32'(we_pos), (st && !mis) ? 32'(exp_lat - 1) : 32'hFFFF_FFFF);
    check({nm, " busy_ready"}, 32'(early_ready), 32'd0);
    if (!mis) check({nm, " dm_addr"}, addr_seen, {addr[31:2], 2'b00});

    if (st && !mis) begin
      case (op)
        SB: rb[a] = wd[7:0];
        SH: begin rb[a] = wd[15:8]; rb[8'(a + 8'd1)] = wd[7:0]; end
        default: for (int i = 0; i < 4; i++) rb[a + i] = wd[31-8*i -: 8];
      endcase
    end
    check({nm, " mem_word"}, mem[a[7:2]], ref_word(a));
  endtask

  task automatic simple(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd);
    run_op(op, addr, wd, 1'b0, LB, 32'd0, 32'd0);
  endtask

  initial begin
    bit bad_we, bad_resp;
    logic [31:0] w_before, addr;
    mem_op_t op;

    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 64; i++) set_word(8'(i * 4), $urandom);
    set_word(8'h10, 32'h8022_3344);

    // Reset values.
    #2;
    check("rst req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst resp_misalign", {31'd0, bus.resp_misalign}, 32'd0);
    check("rst resp_rdata", bus.resp_rdata, 32'd0);
    check("rst dm_addr", bus.dm_addr, 32'd0);
    check("rst dm_wd", bus.dm_wd, 32'd0);
    check("rst dm_we", {31'd0, bus.dm_we}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed loads, sub-word store, misaligned accesses.
    simple(LW,  32'h10, 32'd0);
    simple(LB,  32'h10, 32'd0);
    simple(LBU, 32'h10, 32'd0);
    simple(LHU, 32'h12, 32'd0);
    simple(LH,  32'h10, 32'd0);
    simple(SB,  32'h11, 32'h0000_00AA);
    check("word10 after SB", mem[4], 32'h80AA_3344);
    simple(LH,  32'h11, 32'd0);
    simple(SW,  32'h12, 32'h1234_5678);
    simple(SH,  32'h22, 32'h0000_CAFE);
    simple(LW,  32'hFFFF_FF20, 32'd0);

    // Reset pulsed during the READ of an SH.
    w_before = mem[4];
    bus.req_op = SH; bus.req_addr = 32'h12; bus.req_wdata = 32'h0000_BEEF; bus.req_valid = 1'b1;
    for (int i = 0; i < 10 && !bus.req_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("abort req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("abort dm_we", {31'd0, bus.dm_we}, 32'd0);
    check("abort dm_addr", bus.dm_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad_we = 0; bad_resp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.dm_we) bad_we = 1;
      if (bus.resp_valid) bad_resp = 1;
    end
    check("abort no write", {31'd0, bad_we}, 32'd0);
    check("abort no resp", {31'd0, bad_resp}, 32'd0);
    check("abort word", mem[4], w_before);
    check("abort word ref", mem[4], ref_word(8'h10));
    check("abort ready after", {31'd0, bus.req_ready}, 32'd1);

    // Two SW with req_valid held: the second waits for the first response.
    run_op(SW, 32'h30, 32'hAAAA_0001, 1'b1, SW, 32'h34, 32'hBBBB_0002);
    run_op(SW, 32'h34, 32'hBBBB_0002, 1'b0, LB, 32'd0, 32'd0);
    check("held second waits", 32'(last_waits), 32'd1);
    check("held first word", mem[12], 32'hAAAA_0001);
    check("held second word", mem[13], 32'hBBBB_0002);

    // Randomized mix.
    for (int n = 0; n < 40; n++) begin
      op = mem_op_t'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      simple(op, addr, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
